// File: rtl/exu_mul_4.sv
// Single-issue integer multiply unit (MUL/MULH/MULHSU/MULHU): IDLE -> BUSY for MUL_LAT cycles -> DONE until the ROB takes the fill.
// Optional build macro EXU_MUL_4_EARLY_ZERO_EN: zero-operand ops skip BUSY and complete the cycle after accept.
module exu_mul_4 #(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 6,
  parameter int MUL_LAT   = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [XLEN-1:0]      in_src1,
  input  logic [XLEN-1:0]      in_src2,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  output logic                 fill_valid,
  input  logic                 fill_ready,
  output logic [ROB_IDX_W-1:0] fill_rob_idx,
  output logic [XLEN-1:0]      fill_data,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(MUL_LAT - 1);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [XLEN-1:0]      src1_q, src1_d, src2_q, src2_d, res_q, res_d;
  logic [ROB_IDX_W-1:0] tag_q, tag_d;

  logic                 accept;
  logic                 a_sgn, b_sgn;
  logic [2*XLEN-1:0]    a_ext, b_ext, prod;
  logic [XLEN-1:0]      prod_sel;

  assign in_ready     = (state_q == S_IDLE) && !flush;
  assign accept       = in_valid && in_ready;
  assign fill_valid   = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign fill_data    = res_q;
  assign fill_rob_idx = tag_q;

  // Sign-extend to 2*XLEN; the truncated product is exact for every signedness mix.
  assign a_sgn    = (op_q == 2'b01) || (op_q == 2'b10);
  assign b_sgn    = (op_q == 2'b01);
  assign a_ext    = {{XLEN{a_sgn & src1_q[XLEN-1]}}, src1_q};
  assign b_ext    = {{XLEN{b_sgn & src2_q[XLEN-1]}}, src2_q};
  assign prod     = a_ext * b_ext;
  assign prod_sel = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    tag_d   = tag_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = in_op;
          src1_d  = in_src1;
          src2_d  = in_src2;
          tag_d   = in_rob_idx;
          cnt_d   = '0;
          state_d = S_BUSY;
`ifdef EXU_MUL_4_EARLY_ZERO_EN
          if ((in_src1 == '0) || (in_src2 == '0)) begin
            res_d   = '0;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          res_d   = prod_sel;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (fill_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Flush wins over everything; a squashed op never reaches DONE.
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      tag_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_exu_mul_4.sv
// Directed bench for exu_mul_4: vector table for results/latency, plus backpressure, flush and reset sequences.
module tb_exu_mul_4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_src1 = '0, in_src2 = '0;
  logic [5:0]  in_rob_idx = '0;
  logic        fill_valid;
  logic        fill_ready = 1'b1;
  logic [5:0]  fill_rob_idx;
  logic [31:0] fill_data;
  logic        busy;

  int nchk = 0;
  int nerr = 0;

  exu_mul_4 #(.XLEN(32), .ROB_IDX_W(6), .MUL_LAT(4)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_rob_idx(in_rob_idx),
    .fill_valid(fill_valid), .fill_ready(fill_ready),
    .fill_rob_idx(fill_rob_idx), .fill_data(fill_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef EXU_MUL_4_EARLY_ZERO_EN
    if (a == 0 || b == 0) return 0;
`endif
    return 4;
  endfunction

  // Entered and left just after a falling edge; latency = rising edges after the accept edge.
  task automatic wait_fill(output int n);
    n = 0;
    @(negedge clk);
    while (!fill_valid && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag);
    in_op = op; in_src1 = a; in_src2 = b; in_rob_idx = tag; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] tag, input logic [31:0] exp);
    int n;
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    issue(op, a, b, tag);
    wait_fill(n);
    chk({nm, "_latency"}, 32'(n), 32'(exp_lat(a, b)));
    chk({nm, "_data"}, fill_data, exp);
    chk({nm, "_tag"}, 32'(fill_rob_idx), 32'(tag));
    @(negedge clk);
    chk({nm, "_idle_after"}, {30'd0, busy, in_ready}, 32'd1);
  endtask

  initial begin
    int n;
    logic bad;
    vt[0]  = '{2'b00, 32'd7,        32'd6,        6'd5,  32'h0000002A};
    vt[1]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd1,  32'hFFFFFFFE};
    vt[2]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd2,  32'h00000000};
    vt[3]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd3,  32'hFFFFFFFF};
    vt[4]  = '{2'b01, 32'h80000000, 32'h80000000, 6'd10, 32'h40000000};
    vt[5]  = '{2'b11, 32'h80000000, 32'h00000002, 6'd11, 32'h00000001};
    vt[6]  = '{2'b01, 32'hFFFFFFFE, 32'h00000003, 6'd12, 32'hFFFFFFFF};
    vt[7]  = '{2'b10, 32'h00000002, 32'hFFFFFFFF, 6'd13, 32'h00000001};
    vt[8]  = '{2'b00, 32'h12345678, 32'h00000010, 6'd14, 32'h23456780};
    vt[9]  = '{2'b00, 32'h80000000, 32'h00000002, 6'd15, 32'h00000000};
    vt[10] = '{2'b00, 32'h00000000, 32'h00000005, 6'd16, 32'h00000000};
    vt[11] = '{2'b11, 32'h00000005, 32'h00000000, 6'd63, 32'h00000000};

    // Reset state
    #12;
    chk("rst_fill_valid", 32'(fill_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fill_data", fill_data, 32'd0);
    chk("rst_fill_tag", 32'(fill_rob_idx), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

    foreach (vt[i])
      do_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].tag, vt[i].exp);

    // Backpressure: result and tag hold, no accept while DONE.
    fill_ready = 1'b0;
    issue(2'b00, 32'd3, 32'd3, 6'd9);
    wait_fill(n);
    chk("bp_latency", 32'(n), 32'd4);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_op = 2'b00; in_src1 = 32'd11; in_src2 = 32'd13; in_rob_idx = 6'd20; in_valid = 1'b1;
      if (!fill_valid || fill_data !== 32'h9 || fill_rob_idx !== 6'd9 || in_ready) bad = 1'b1;
      @(negedge clk);
    end
    chk("bp_hold", 32'(bad), 32'd0);
    in_valid = 1'b0;
    chk("bp_data_end", fill_data, 32'h9);
    fill_ready = 1'b1;
    @(negedge clk);
    chk("bp_after_hs", {30'd0, fill_valid, in_ready}, 32'd1);
    @(negedge clk);
    chk("bp_single_hs", 32'(fill_valid), 32'd0);

    // Flush two cycles after accept, with an issue attempt in the flush cycle.
    issue(2'b00, 32'd7, 32'd6, 6'd3);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    in_op = 2'b00; in_src1 = 32'd2; in_src2 = 32'd2; in_rob_idx = 6'd7; in_valid = 1'b1;
    #1 chk("fl_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("fl_idle", {30'd0, busy, fill_valid}, 32'd0);
    do_op("fl_next", 2'b00, 32'd5, 32'd5, 6'd4, 32'd25);

    // Flush while DONE and stalled drops the result.
    fill_ready = 1'b0;
    issue(2'b11, 32'hFFFFFFFF, 32'h2, 6'd8);
    wait_fill(n);
    chk("fld_latency", 32'(n), 32'd4);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; fill_ready = 1'b1;
    @(negedge clk);
    chk("fld_idle", {30'd0, busy, fill_valid}, 32'd0);

    // Reset pulse while BUSY: outputs clear immediately, no fill afterwards.
    issue(2'b00, 32'd7, 32'd6, 6'd2);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_fill_valid", 32'(fill_valid), 32'd0);
    chk("rmid_fill_data", fill_data, 32'd0);
    chk("rmid_fill_tag", 32'(fill_rob_idx), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fill_valid || busy) bad = 1'b1;
    end
    chk("rmid_no_fill", 32'(bad), 32'd0);
    chk("rmid_in_ready", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/exu_mul_4.md
EXU_MUL_4 -- requirements
Module: exu_mul_4

Interface
REQ-001 Parameter XLEN, 32, operand/result width.
REQ-002 Parameter ROB_IDX_W, 6, ROB tag width.
REQ-003 Parameter MUL_LAT, 4, BUSY cycles per operation, range 1..15.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rstn  in  1  reset; asynchronous, active-low.
REQ-006 flush  in  1  pipeline flush from global command block; squashes in-flight op.
REQ-007 in_valid  in  1  issue from the reservation station; RSV_4 execute broadcast is valid.
REQ-008 in_ready  out  1  unit can accept an issue this cycle.
REQ-009 in_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-010 in_src1, in_src2  in  XLEN  operands; src1 is the signed operand for MULHSU.
REQ-011 in_rob_idx  in  ROB_IDX_W  destination ROB tag.
REQ-012 fill_valid  out  1  result presented to ROB fill port.
REQ-013 fill_ready  in  1  ROB accepts fill this cycle.
REQ-014 fill_rob_idx  out  ROB_IDX_W  tag of the presented result.
REQ-015 fill_data  out  XLEN  result.
REQ-016 busy  out  1  state is not IDLE.

Function
REQ-017 The unit SHALL implement an FSM with states IDLE, BUSY, DONE.
REQ-018 in_ready SHALL be 1 only when state is IDLE and flush is 0.
REQ-019 Accept = in_valid & in_ready at a rising edge; on accept the unit SHALL latch op, operands, and tag, set cnt=0, and enter BUSY.
REQ-020 In BUSY, cnt SHALL increment each cycle; when cnt==MUL_LAT-1, the next state SHALL be DONE.
REQ-021 fill_valid SHALL be 1 exactly when state is DONE; the first fill_valid cycle is MUL_LAT+1 cycles after the accept edge.
REQ-022 In DONE, fill_data and fill_rob_idx SHALL hold stable until fill_valid & fill_ready; the unit then SHALL return to IDLE on that edge.
REQ-023 There is no overlap: a new accept SHALL occur no earlier than the cycle after the fill handshake.
REQ-024 Result: form the 2*XLEN product; MUL SHALL return the low XLEN bits; MULH SHALL return the high bits signed x signed; MULHSU SHALL return the high bits signed(src1) x unsigned(src2); MULHU SHALL return the high bits unsigned x unsigned.
REQ-025 The internal product implementation is free (iterative or combinational+registered), provided the REQ-020/021 timing holds.
REQ-026 flush=1 in any state SHALL force IDLE at the next edge, with no fill issued for the squashed op.
REQ-027 flush coincident with in_valid SHALL block acceptance, because in_ready is 0.
REQ-028 flush coincident with a DONE handshake SHALL still go to IDLE; the ROB owns squash of that tag.
REQ-029 fill_ready held 0 indefinitely SHALL hold DONE and the outputs with no data loss.

Reset
REQ-030 While rstn=0: state=IDLE, cnt=0, fill_valid=0, busy=0, fill_data=0, fill_rob_idx=0, latched operands=0; in_ready=1 after deassertion.
REQ-031 Reset asserted mid-operation SHALL abandon the op immediately (asynchronously), with no fill after release.

Configuration
REQ-032 Macro EXU_MUL_4_EARLY_ZERO_EN. Defined: an accept with in_src1==0 or in_src2==0 SHALL go directly to DONE with fill_data=0, with fill_valid 1 cycle after the accept edge. Undefined: every op takes the full MUL_LAT path of REQ-020/021.

Verification
REQ-033 MUL 7 x 6, tag 5, fill_ready=1 -> fill_valid in cycle 5 after accept, data 0x0000002A, tag 5, then IDLE and in_ready=1.
REQ-034 MULHU / MULH / MULHSU with 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE / 0x00000000 / 0xFFFFFFFF respectively.
REQ-035 MUL 3 x 3 with fill_ready=0 for 10 cycles, then 1 -> data 0x9 held stable the whole time, one handshake, in_ready low until after it.
REQ-036 Flush 2 cycles after accept -> IDLE next cycle, no fill_valid ever for that tag; a new op accepted the next cycle completes correctly.
REQ-037 MUL 0 x 5 -> with EXU_MUL_4_EARLY_ZERO_EN: fill_valid 1 cycle after accept, data 0; without it: fill_valid at cycle 5, data 0.
REQ-038 rstn pulsed low while BUSY -> outputs zero immediately; no fill_valid after release.
